tx_buffer_crc: RTL and testbench



---
 rtl/tx_buffer_crc_pkg.sv | 18 +
 rtl/tx_buffer_crc_crc32.sv | 56 +++++
 rtl/tx_buffer_crc_sync_fifo.sv | 62 ++++++
 rtl/tx_buffer_crc.sv | 56 +++++
 tb/tb_tx_buffer_crc.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/tx_buffer_crc_pkg.sv
// Shared constants and the reflected CRC-32 byte update for the TX buffer/FCS block.
package tx_buffer_crc_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Fold one byte into a reflected (LSB-first) CRC-32 register.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_buffer_crc_crc32.sv
// Slice-by-N Ethernet CRC-32 over byte-masked words; lanes fold in ascending order.
module crc32
  import tx_buffer_crc_pkg::*;
#(
  parameter int unsigned SLICE_LENGTH    = 4,
  parameter logic [31:0] INITIAL_CRC     = CRC_INIT,
  parameter bit          INVERT_OUTPUT   = 1'b1,
  parameter bit          REGISTER_OUTPUT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reset,
  input  logic [8*SLICE_LENGTH-1:0] in_data,
  input  logic [SLICE_LENGTH-1:0]   in_valid,
  output logic [31:0]               out_crc
);

  localparam logic [31:0] INIT_VIS = INVERT_OUTPUT ? ~INITIAL_CRC : INITIAL_CRC;
  localparam logic [31:0] INIT_OUT = {INIT_VIS[7:0], INIT_VIS[15:8], INIT_VIS[23:16], INIT_VIS[31:24]};

  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [31:0] crc_vis;
  logic [31:0] crc_swapped;

  // Chain one byte stage per valid lane; skipped lanes pass the value through.
  always_comb begin
    crc_next = crc;
    for (int unsigned k = 0; k < SLICE_LENGTH; k++) begin
      if (in_valid[k]) crc_next = crc32_byte(crc_next, in_data[8*k +: 8]);
    end
  end

  // CRC register: async reset, synchronous re-init overriding the data mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       crc <= INITIAL_CRC;
    else if (reset) crc <= INITIAL_CRC;
    else            crc <= crc_next;
  end

  assign crc_vis     = INVERT_OUTPUT ? ~crc : crc;
  assign crc_swapped = {crc_vis[7:0], crc_vis[15:8], crc_vis[23:16], crc_vis[31:24]};

  if (REGISTER_OUTPUT) begin : g_reg_out
    logic [31:0] out_q;
    // Optional output stage adding one cycle of latency.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) out_q <= INIT_OUT;
      else      out_q <= crc_swapped;
    end
    assign out_crc = out_q;
  end else begin : g_comb_out
    assign out_crc = crc_swapped;
  end

endmodule

// File: rtl/tx_buffer_crc_sync_fifo.sv
// Synchronous single-clock FIFO with registered read data and occupancy counter.
module sync_fifo
  import tx_buffer_crc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // A write while full is still accepted when a read frees the slot in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_en);

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered read word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_buffer_crc.sv
// MAC TX support block: frame FIFO plus FCS engine sharing clock and reset.
module tx_buffer_crc
  import tx_buffer_crc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 36,
  parameter int unsigned ADDR_WIDTH      = 9,
  parameter int unsigned FIFO_DEPTH      = 512,
  parameter int unsigned SLICE_LENGTH    = 4,
  parameter logic [31:0] INITIAL_CRC     = CRC_INIT,
  parameter bit          INVERT_OUTPUT   = 1'b1,
  parameter bit          REGISTER_OUTPUT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      full,
  output logic                      empty,
  input  logic                      crc_init,
  input  logic [8*SLICE_LENGTH-1:0] in_data,
  input  logic [SLICE_LENGTH-1:0]   in_valid,
  output logic [31:0]               out_crc
);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  crc32 #(
    .SLICE_LENGTH    (SLICE_LENGTH),
    .INITIAL_CRC     (INITIAL_CRC),
    .INVERT_OUTPUT   (INVERT_OUTPUT),
    .REGISTER_OUTPUT (REGISTER_OUTPUT)
  ) u_crc (
    .clk      (clk),
    .rst      (rst),
    .reset    (crc_init),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_crc  (out_crc)
  );

endmodule

// File: tb/tb_tx_buffer_crc.sv
// Directed scoreboard bench for tx_buffer_crc (FIFO ordering/flags, CRC vectors, residue).
module tb_tx_buffer_crc;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [35:0] wr_data;
  logic        rd_en;
  logic [35:0] rd_data;
  logic        full;
  logic        empty;
  logic        crc_init;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [31:0] out_crc;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [35:0] fq[$];
  logic [31:0] cq[$];
  int          m_cnt;
  logic [35:0] last_rd;
  logic [31:0] m_crc;

  tx_buffer_crc dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .crc_init (crc_init),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_crc  (out_crc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: shift LSB out, apply polynomial on feedback.
  function automatic logic [31:0] m_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  function automatic logic [31:0] fcs_out(input logic [31:0] c);
    logic [31:0] v;
    v = ~c;
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic fifo_cycle(input logic we, input logic [35:0] wd, input logic re);
    logic wa;
    logic ra;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    ra = re && (m_cnt > 0);
    wa = we && ((m_cnt < 512) || re);
    if (ra) last_rd = fq.pop_front();
    if (wa) fq.push_back(wd);
    m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
    @(posedge clk); #1;
    chk("rd_data", 64'(rd_data), 64'(last_rd));
    chk("full",    64'(full),    64'(m_cnt == 512));
    chk("empty",   64'(empty),   64'(m_cnt == 0));
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic crc_cycle(input logic [31:0] d, input logic [3:0] mask, input logic init);
    in_data  = d;
    in_valid = mask;
    crc_init = init;
    if (init) m_crc = 32'hFFFFFFFF;
    else begin
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) m_crc = m_byte(m_crc, d[8*k +: 8]);
      end
    end
    cq.push_back(fcs_out(m_crc));
    @(posedge clk); #1;
    chk("out_crc", 64'(out_crc), 64'(cq.pop_front()));
    in_valid = '0;
    crc_init = 1'b0;
  endtask

  task automatic crc_check_vector();
    crc_cycle(32'h34333231, 4'b1111, 1'b0);
    crc_cycle(32'h38373635, 4'b1111, 1'b0);
    crc_cycle(32'h00000039, 4'b0001, 1'b0);
    chk("crc_123456789", 64'(out_crc), 64'(32'h2639F4CB));
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    crc_init = 1'b0; in_data = '0; in_valid = '0;
    m_cnt = 0; last_rd = '0; m_crc = 32'hFFFFFFFF;

    #21;
    chk("rst_empty",   64'(empty),   64'(1));
    chk("rst_full",    64'(full),    64'(0));
    chk("rst_out_crc", 64'(out_crc), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single word through
    fifo_cycle(1'b1, 36'h1_00000055, 1'b0);
    fifo_cycle(1'b0, '0, 1'b1);
    chk("first_word", 64'(rd_data), 64'(36'h1_00000055));

    // Read+write while empty: only the write lands, rd_data holds
    fifo_cycle(1'b1, 36'hA_BCDEF012, 1'b1);
    fifo_cycle(1'b0, '0, 1'b1);

    // Fill, drop on full, read+write at full, drain
    for (int i = 0; i < 512; i++) fifo_cycle(1'b1, 36'(i), 1'b0);
    chk("full_after_512", 64'(full), 64'(1));
    fifo_cycle(1'b1, 36'hF_FFFFFFFF, 1'b0);
    fifo_cycle(1'b1, 36'h5_5555AAAA, 1'b1);
    for (int i = 0; i < 512; i++) fifo_cycle(1'b0, '0, 1'b1);
    chk("empty_after_drain", 64'(empty), 64'(1));
    fifo_cycle(1'b0, '0, 1'b1);

    // Streaming at occupancy 1 across pointer wrap
    fifo_cycle(1'b1, 36'h7_00000000, 1'b0);
    for (int i = 0; i < 600; i++) fifo_cycle(1'b1, 36'h3_00000000 | 36'(i), 1'b1);
    fifo_cycle(1'b0, '0, 1'b1);

    // CRC: init and check vector
    crc_cycle(32'h0, 4'b0000, 1'b1);
    chk("crc_after_init", 64'(out_crc), 64'(0));
    crc_check_vector();

    // Leading 1110 mask then full words
    crc_cycle(32'h0, 4'b0000, 1'b1);
    crc_cycle(32'h333231FF, 4'b1110, 1'b0);
    crc_cycle(32'h37363534, 4'b1111, 1'b0);
    crc_cycle(32'h00003938, 4'b0011, 1'b0);
    chk("crc_mask_1110", 64'(out_crc), 64'(32'h2639F4CB));

    // Mixed masks including an idle 0000 word and a lone top lane
    crc_cycle(32'h0, 4'b0000, 1'b1);
    crc_cycle(32'hAAAAAA31, 4'b0001, 1'b0);
    crc_cycle(32'h55343332, 4'b0111, 1'b0);
    crc_cycle(32'h12345678, 4'b0000, 1'b0);
    crc_cycle(32'h38373635, 4'b1111, 1'b0);
    crc_cycle(32'h39000000, 4'b1000, 1'b0);
    chk("crc_mixed_masks", 64'(out_crc), 64'(32'h2639F4CB));

    // Init mid-stream with a full mask restarts the CRC
    crc_cycle(32'hDEADBEEF, 4'b1111, 1'b0);
    crc_cycle(32'hFFFFFFFF, 4'b1111, 1'b1);
    crc_check_vector();

    // Residue: 60 zero bytes then the FCS
    crc_cycle(32'h0, 4'b0000, 1'b1);
    for (int i = 0; i < 15; i++) crc_cycle(32'h0, 4'b1111, 1'b0);
    crc_cycle(~m_crc, 4'b1111, 1'b0);
    chk("crc_residue", 64'(out_crc), 64'(32'h1CDF4421));

    // Asynchronous reset mid-frame
    crc_cycle(32'h12345678, 4'b1111, 1'b0);
    fifo_cycle(1'b1, 36'h9_87654321, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out_crc", 64'(out_crc), 64'(0));
    chk("midrst_empty",   64'(empty),   64'(1));
    chk("midrst_rd_data", 64'(rd_data), 64'(0));
    fq.delete(); m_cnt = 0; last_rd = '0; m_crc = 32'hFFFFFFFF;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    crc_check_vector();
    fifo_cycle(1'b1, 36'h2_0000BEEF, 1'b0);
    fifo_cycle(1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
